clock_set_controller: RTL and testbench

//  Timekeeping and time-set controller feeding the 4-digit 7-segment clock display.

---
 rtl/clock_set_controller.sv | 115 +++++++++++
 tb/tb_clock_set_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller: 24 h timekeeping with RUN / SET_MIN / SET_HOUR time-set state machine
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   btn_mode : raw mode button (async, active-high)
//   btn_inc  : raw increment button (async, active-high)
//   hour     : hours 0..23
//   minute   : minutes 0..59
//   mode     : 0 RUN, 1 SET_MIN, 2 SET_HOUR
//   sec_tick : one-cycle pulse per prescaler wrap
module clock_set_controller #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_PER   = 10_000_000,
    parameter int TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] hour,
    output logic [6:0] minute,
    output logic [1:0] mode,
    output logic       sec_tick
);
    localparam int PW = $clog2(CLK_HZ);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_HOUR = 2'd2} state_t;
    state_t             state_q, state_d;
    logic [1:0]         s1_q, s2_q, db_q, db_d, flip, press;
    logic [1:0][DW-1:0] dbc_q, dbc_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic               tick_q;
    logic [RW-1:0]      rpt_q, rpt_d;
    logic [TW-1:0]      to_q, to_d;
    logic [5:0]         sec_q, sec_d;
    logic [6:0]         min_q, min_d, hour_q, hour_d;
    logic               mode_evt, inc_evt, inc_rel, rpt_hit, rpt_fire, timeout, bump;
    logic               enter_min, run_tick, min_carry, hour_carry;
    // Bit 0 is the mode button, bit 1 the increment button. A level flips once the
    // synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles.
    always_comb begin
        flip  = '0;
        db_d  = db_q;
        dbc_d = dbc_q;
        for (int b = 0; b < 2; b++) begin
            flip[b]  = (s2_q[b] != db_q[b]) && (dbc_q[b] == DW'(DEBOUNCE_CYC - 1));
            db_d[b]  = flip[b] ? s2_q[b] : db_q[b];
            dbc_d[b] = (s2_q[b] == db_q[b] || flip[b]) ? '0 : dbc_q[b] + DW'(1);
        end
    end
    assign press    = flip & s2_q;
    assign mode_evt = press[0];
    assign inc_evt  = press[1];
    // A repeat coinciding with the release edge is dropped: the button is already let go.
    assign inc_rel  = flip[1] & ~s2_q[1];
    assign rpt_hit  = db_q[1] & ~inc_rel & (rpt_q == RW'(REPEAT_DLY - 1));
    assign rpt_fire = rpt_hit & (state_q != RUN);
    assign rpt_d    = (inc_evt || !db_q[1]) ? '0 :
                      rpt_hit ? RW'(REPEAT_DLY - REPEAT_PER) : rpt_q + RW'(1);
    assign timeout  = (state_q != RUN) && tick_q && !inc_evt && (to_q == TW'(TIMEOUT_S - 1));
    always_comb begin
        state_d    = timeout ? RUN : !mode_evt ? state_q :
                     state_q == RUN ? SET_MIN : state_q == SET_MIN ? SET_HOUR : RUN;
        enter_min  = (state_d == SET_MIN) && (state_q != SET_MIN);
        to_d       = (|press || state_d != state_q) ? '0 :
                     (state_q != RUN && tick_q) ? to_q + TW'(1) : to_q;
        // Entering SET_MIN restarts the second so RUN resumes on an exact boundary.
        pre_d      = (enter_min || tick_q) ? '0 : pre_q + PW'(1);
        run_tick   = (state_q == RUN) && tick_q;
        bump       = (inc_evt || rpt_fire) && !mode_evt;
        sec_d      = enter_min ? '0 : !run_tick ? sec_q : sec_q == 6'd59 ? '0 : sec_q + 6'd1;
        min_carry  = run_tick && sec_q == 6'd59;
        hour_carry = min_carry && min_q == 7'd59;
        min_d      = (min_carry || (state_q == SET_MIN && bump)) ?
                     (min_q == 7'd59 ? '0 : min_q + 7'd1) : min_q;
        hour_d     = (hour_carry || (state_q == SET_HOUR && bump)) ?
                     (hour_q == 7'd23 ? '0 : hour_q + 7'd1) : hour_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            dbc_q   <= '0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            rpt_q   <= '0;
            to_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            state_q <= RUN;
        end else begin
            s1_q    <= {btn_inc, btn_mode};
            s2_q    <= s1_q;
            db_q    <= db_d;
            dbc_q   <= dbc_d;
            pre_q   <= pre_d;
            tick_q  <= pre_d == PW'(CLK_HZ - 1);
            rpt_q   <= rpt_d;
            to_q    <= to_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            state_q <= state_d;
        end
    end
    assign hour     = hour_q;
    assign minute   = min_q;
    assign mode     = state_q;
    assign sec_tick = tick_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed vector table plus multi-cycle corner sequences
module tb_clock_set_controller;
    logic       clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [6:0] hour, minute;
    logic [1:0] mode;
    logic       sec_tick;
    int         checks = 0, errors = 0;
    int         exp_mode = 0, exp_h = 0, exp_m = 0;
    int         ticks = 0, done = 0, seen = 0;

    typedef struct {
        logic bm;
        logic bi;
        int   hold;
        int   e_mode;
        int   e_hour;
        int   e_min;
    } vec_t;
    vec_t tbl [12];

    clock_set_controller #(
        .CLK_HZ(100), .DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(5), .TIMEOUT_S(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hour(hour), .minute(minute), .mode(mode), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        checks++;
        if (act !== 32'(expv)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // One clean 8-cycle press, then settle; the model follows the state machine rules.
    task automatic tap(input logic bm, input logic bi);
        btn_mode = bm;
        btn_inc  = bi;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
        if (bm) exp_mode = (exp_mode == 2) ? 0 : exp_mode + 1;
        else if (bi && exp_mode == 1) exp_m = (exp_m + 1) % 60;
        else if (bi && exp_mode == 2) exp_h = (exp_h + 1) % 24;
        chk("tap mode", mode, exp_mode);
        chk("tap hour", hour, exp_h);
        chk("tap minute", minute, exp_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 8, 1, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 8, 1, 0, 1};
        tbl[3]  = '{1'b0, 1'b1, 8, 1, 0, 2};
        tbl[4]  = '{1'b1, 1'b0, 3, 1, 0, 2};
        tbl[5]  = '{1'b0, 1'b1, 3, 1, 0, 2};
        tbl[6]  = '{1'b1, 1'b0, 8, 2, 0, 2};
        tbl[7]  = '{1'b0, 1'b1, 8, 2, 1, 2};
        tbl[8]  = '{1'b1, 1'b1, 8, 0, 1, 2};
        tbl[9]  = '{1'b1, 1'b0, 8, 1, 1, 2};
        tbl[10] = '{1'b1, 1'b1, 8, 2, 1, 2};
        tbl[11] = '{1'b1, 1'b1, 8, 0, 1, 2};
        repeat (2) @(negedge clk);
        chk("reset hour", hour, 0);
        chk("reset minute", minute, 0);
        chk("reset mode", mode, 0);
        chk("reset sec_tick", sec_tick, 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_mode = tbl[i].bm;
            btn_inc  = tbl[i].bi;
            repeat (tbl[i].hold) @(negedge clk);
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            repeat (12) @(negedge clk);
            chk($sformatf("vec%0d mode", i), mode, tbl[i].e_mode);
            chk($sformatf("vec%0d hour", i), hour, tbl[i].e_hour);
            chk($sformatf("vec%0d minute", i), minute, tbl[i].e_min);
        end
        exp_mode = 0; exp_h = 1; exp_m = 2;
        // Mode press latency: 2 sync + 4 debounce cycles.
        btn_mode = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) chk("latency before", mode, 0);
            if (k == 6) chk("latency at 6", mode, 1);
        end
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        exp_mode = 1;
        // Minute wrap without hour carry, then hour wrap.
        while (exp_m != 58) tap(1'b0, 1'b1);
        repeat (3) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        while (exp_h != 23) tap(1'b0, 1'b1);
        tap(1'b0, 1'b1);
        // Auto-repeat from hour 5 with a 40-cycle hold.
        while (exp_h != 5) tap(1'b0, 1'b1);
        btn_inc = 1'b1;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            chk($sformatf("repeat k%0d", k), hour,
                5 + int'(k >= 6) + int'(k >= 26) + int'(k >= 31) + int'(k >= 36) + int'(k >= 41));
            if (k == 40) btn_inc = 1'b0;
        end
        exp_h = 10;
        repeat (5) @(negedge clk);
        // Load 23:59 and roll over in RUN.
        tap(1'b1, 1'b0);
        tap(1'b1, 1'b0);
        while (exp_m != 59) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        while (exp_h != 23) tap(1'b0, 1'b1);
        btn_mode = 1'b1;
        for (int c = 1; c <= 7000 && done == 0; c++) begin
            @(negedge clk);
            if (c == 8) btn_mode = 1'b0;
            if (seen == 0 && mode == 2'd0) begin
                seen  = 1;
                ticks = 0;
            end
            if (seen != 0) begin
                if (hour != 7'd23 || minute != 7'd59) done = 1;
                else if (sec_tick) ticks++;
            end
        end
        chk("rollover reached", done, 1);
        chk("rollover hour", hour, 0);
        chk("rollover minute", minute, 0);
        chk("rollover ticks", ticks, 60);
        chk("rollover mode", mode, 0);
        exp_mode = 0; exp_h = 0; exp_m = 0;
        // Timeout in SET_MIN after 3 idle seconds, edited minute kept.
        btn_mode = 1'b1;
        for (int k = 1; k <= 310; k++) begin
            @(negedge clk);
            if (k == 5) chk("timeout mode pre", mode, 0);
            if (k == 6) chk("timeout mode set", mode, 1);
            if (k == 8) btn_mode = 1'b0;
            if (k == 16) btn_inc = 1'b1;
            if (k == 21) chk("timeout minute pre", minute, 0);
            if (k == 22) chk("timeout minute inc", minute, 1);
            if (k == 24) btn_inc = 1'b0;
            if (k == 104) chk("timeout tick 104", sec_tick, 0);
            if (k == 105) chk("timeout tick 105", sec_tick, 1);
            if (k == 106) chk("timeout tick 106", sec_tick, 0);
            if (k == 305) chk("timeout mode 305", mode, 1);
            if (k == 306) chk("timeout mode 306", mode, 0);
        end
        chk("timeout minute kept", minute, 1);
        chk("timeout hour kept", hour, 0);
        exp_m = 1;
        // Reset mid-count at 12:34.
        tap(1'b1, 1'b0);
        while (exp_m != 34) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        while (exp_h != 12) tap(1'b0, 1'b1);
        tap(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        chk("pre-reset hour", hour, 12);
        chk("pre-reset minute", minute, 34);
        #2 rst = 1'b1;
        #1;
        chk("async reset hour", hour, 0);
        chk("async reset minute", minute, 0);
        chk("async reset mode", mode, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            if (k == 98) chk("post-reset tick 98", sec_tick, 0);
            if (k == 99) chk("post-reset tick 99", sec_tick, 1);
        end
        exp_mode = 0; exp_h = 0; exp_m = 0;
        tap(1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
